// File: rtl/rgb2grey_frame_ctrl.sv
// rgb2grey_frame_ctrl
// Frame-level sequencer around a combinational shift-add RGB-to-grey
// converter. Pixels enter over valid/ready and leave from a one-deep
// registered output stage. The output stage carries start-of-frame,
// end-of-line and end-of-frame markers. Firmware starts one frame at a
// time and receives a done pulse when the frame has fully drained.

module rgb2grey_frame_ctrl #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int XW    = 10,
   parameter int YW    = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [23:0] s_rgb,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  m_grey,
   output logic        m_sof,
   output logic        m_eol,
   output logic        m_eof,
   output logic        busy,
   output logic        done,
   output logic [15:0] frame_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   // Shift-add luma approximation; every partial sum wraps at 8 bits.
   function automatic logic [7:0] rgb_to_grey(input logic [23:0] rgb);
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic [7:0] sum;
      r   = rgb[23:16] >> 3'd2;
      sum = r;
      r   = r >> 3'd3;
      sum = sum + r;
      r   = r >> 3'd1;
      sum = sum + r;
      g   = rgb[15:8] >> 3'd1;
      sum = sum + g;
      g   = g >> 3'd3;
      sum = sum + g;
      g   = g >> 3'd2;
      sum = sum + g;
      g   = g >> 3'd1;
      sum = sum + g;
      b   = rgb[7:0] >> 3'd4;
      sum = sum + b;
      b   = b >> 3'd1;
      sum = sum + b;
      b   = b >> 3'd1;
      sum = sum + b;
      b   = b >> 3'd2;
      sum = sum + b;
      return sum + 8'd5;
   endfunction

   logic [1:0]    state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          m_valid_q;
   logic [7:0]    m_grey_q;
   logic          m_sof_q, m_eol_q, m_eof_q;
   logic          busy_q, done_q;
   logic [15:0]   frame_cnt_q, frame_cnt_d;

   logic          ready;
   logic          accept;
   logic          last_px;
   logic          out_free;

   // The output register can take a new pixel when empty or emptying this cycle.
   assign out_free = !m_valid_q || m_ready;
   assign ready    = (state_q == ST_RUN) && out_free;
   assign accept   = s_valid && ready;
   assign last_px  = (x_q == X_LAST) && (y_q == Y_LAST);

   // Frame sequencing and pixel position tracking; abort overrides everything.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      frame_cnt_d = frame_cnt_q;
      if (abort) begin
         state_d = ST_IDLE;
         x_d     = '0;
         y_d     = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_RUN;
                  x_d     = '0;
                  y_d     = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  if (last_px) begin
                     // Final pixel: park the counters rather than wrap into a new frame.
                     state_d = ST_DRAIN;
                     x_d     = '0;
                     y_d     = '0;
                  end else if (x_q == X_LAST) begin
                     state_d = ST_RUN;
                     x_d     = '0;
                     y_d     = y_q + YW'(1);
                  end else begin
                     state_d = ST_RUN;
                     x_d     = x_q + XW'(1);
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (out_free) begin
                  state_d     = ST_DONE;
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Controller state, position counters and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         frame_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         busy_q      <= (state_d != ST_IDLE);
         done_q      <= (state_d == ST_DONE);
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // One-deep output stage: load on accept, empty on handshake, hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q <= 1'b0;
         m_grey_q  <= 8'd0;
         m_sof_q   <= 1'b0;
         m_eol_q   <= 1'b0;
         m_eof_q   <= 1'b0;
      end else if (abort) begin
         m_valid_q <= 1'b0;
         m_sof_q   <= 1'b0;
         m_eol_q   <= 1'b0;
         m_eof_q   <= 1'b0;
      end else if (accept) begin
         m_valid_q <= 1'b1;
         m_grey_q  <= rgb_to_grey(s_rgb);
         m_sof_q   <= (x_q == '0) && (y_q == '0);
         m_eol_q   <= (x_q == X_LAST);
         m_eof_q   <= last_px;
      end else if (m_valid_q && m_ready) begin
         m_valid_q <= 1'b0;
         m_sof_q   <= 1'b0;
         m_eol_q   <= 1'b0;
         m_eof_q   <= 1'b0;
      end
   end

   assign s_ready   = ready;
   assign m_valid   = m_valid_q;
   assign m_grey    = m_grey_q;
   assign m_sof     = m_sof_q;
   assign m_eol     = m_eol_q;
   assign m_eof     = m_eof_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_rgb2grey_frame_ctrl.sv
// Directed testbench for rgb2grey_frame_ctrl with a 4x2 frame.
// Inputs change on the falling edge; outputs are sampled 1 ns later.

module tb_rgb2grey_frame_ctrl;

   localparam int IMG_W = 4;
   localparam int IMG_H = 2;
   localparam int NPIX  = IMG_W * IMG_H;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        s_valid;
   logic        s_ready;
   logic [23:0] s_rgb;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_grey;
   logic        m_sof, m_eol, m_eof;
   logic        busy;
   logic        done;
   logic [15:0] frame_cnt;

   int          checks = 0;
   int          errors = 0;

   logic [23:0] pix      [NPIX];
   logic [7:0]  got_grey [NPIX];
   logic [2:0]  got_flags[NPIX];
   int          out_cyc  [NPIX];
   int          n_out, extra_out, done_cnt, done_cyc;
   int          stall_seen, stall_changes, s_ready_bad;
   logic [15:0] exp_frames;

   rgb2grey_frame_ctrl #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(2), .YW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready), .s_rgb(s_rgb),
      .m_valid(m_valid), .m_ready(m_ready), .m_grey(m_grey),
      .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
      .busy(busy), .done(done), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Expected {sof,eol,eof} for output index i of a 4x2 frame.
   function automatic logic [2:0] exp_flags(input int i);
      return {i == 0, (i % IMG_W) == IMG_W - 1, i == NPIX - 1};
   endfunction

   // Drives one frame from pix[] and records what comes out; no comparisons here.
   task automatic run_frame(input int stall_start, input int stall_len, input bit start_spam);
      int         sent;
      bit         holding;
      logic [7:0] hold_grey;
      logic [2:0] hold_flags;
      sent = 0; holding = 1'b0; hold_grey = 8'd0; hold_flags = 3'd0;
      n_out = 0; extra_out = 0; done_cnt = 0; done_cyc = -1;
      stall_seen = 0; stall_changes = 0; s_ready_bad = 0;
      for (int i = 0; i < NPIX; i++) begin
         got_grey[i] = 'x; got_flags[i] = 'x; out_cyc[i] = -1;
      end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         s_valid = (sent < NPIX);
         s_rgb   = (sent < NPIX) ? pix[sent] : 24'h000000;
         m_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
         start   = start_spam && (cyc % 3 == 1);
         #1;
         if (m_valid && m_ready) begin
            if (n_out < NPIX) begin
               got_grey[n_out]  = m_grey;
               got_flags[n_out] = {m_sof, m_eol, m_eof};
               out_cyc[n_out]   = cyc;
            end else begin
               extra_out++;
            end
            n_out++;
            holding = 1'b0;
         end else if (m_valid) begin
            stall_seen++;
            if (holding && (m_grey !== hold_grey || {m_sof, m_eol, m_eof} !== hold_flags))
               stall_changes++;
            hold_grey  = m_grey;
            hold_flags = {m_sof, m_eol, m_eof};
            holding    = 1'b1;
            if (s_ready) s_ready_bad++;
         end
         if (s_valid && s_ready) sent++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (done_cnt > 0 && !done) break;
         @(negedge clk);
      end
      start   = 1'b0;
      s_valid = 1'b0;
      m_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
      s_rgb = 24'h000000; m_ready = 1'b1;
      #12;
      checks++;
      if ({m_valid, m_grey, m_sof, m_eol, m_eof, busy, done, frame_cnt, s_ready} !== 31'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h expected 0",
                  {m_valid, m_grey, m_sof, m_eol, m_eof, busy, done, frame_cnt, s_ready});
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle busy=%b s_ready=%b expected 0/0", busy, s_ready);
      end
      exp_frames = 16'd0;
   endtask

   task automatic test_white_frame();
      for (int i = 0; i < NPIX; i++) pix[i] = 24'hFFFFFF;
      run_frame(1000, 0, 1'b0);
      exp_frames = exp_frames + 16'd1;
      checks++;
      if (n_out !== NPIX) begin
         errors++; $display("FAIL white_count got %0d expected %0d", n_out, NPIX);
      end
      for (int i = 0; i < NPIX; i++) begin
         checks++;
         if (got_grey[i] !== 8'hF9 || got_flags[i] !== exp_flags(i)) begin
            errors++;
            $display("FAIL white_px%0d got grey=%h flags=%b expected grey=f9 flags=%b",
                     i, got_grey[i], got_flags[i], exp_flags(i));
         end
      end
      checks++;
      if (out_cyc[NPIX-1] - out_cyc[0] !== NPIX - 1) begin
         errors++;
         $display("FAIL white_rate got span %0d expected %0d", out_cyc[NPIX-1] - out_cyc[0], NPIX - 1);
      end
      checks++;
      if (done_cnt !== 1 || done_cyc !== out_cyc[NPIX-1] + 1) begin
         errors++;
         $display("FAIL white_done got count=%0d cyc=%0d expected 1 at %0d",
                  done_cnt, done_cyc, out_cyc[NPIX-1] + 1);
      end
      checks++;
      if (frame_cnt !== exp_frames || busy !== 1'b0) begin
         errors++;
         $display("FAIL white_status got frame_cnt=%0d busy=%b expected %0d/0", frame_cnt, busy, exp_frames);
      end
   endtask

   task automatic test_colours();
      logic [7:0] exp_g[4];
      exp_g[0] = 8'd5; exp_g[1] = 8'd78; exp_g[2] = 8'd151; exp_g[3] = 8'd30;
      for (int i = 0; i < NPIX; i += 4) begin
         pix[i] = 24'h000000; pix[i+1] = 24'hFF0000; pix[i+2] = 24'h00FF00; pix[i+3] = 24'h0000FF;
      end
      run_frame(1000, 0, 1'b0);
      exp_frames = exp_frames + 16'd1;
      checks++;
      if (n_out !== NPIX || done_cnt !== 1) begin
         errors++; $display("FAIL colour_count got n=%0d done=%0d expected %0d/1", n_out, done_cnt, NPIX);
      end
      for (int i = 0; i < NPIX; i++) begin
         checks++;
         if (got_grey[i] !== exp_g[i % 4]) begin
            errors++; $display("FAIL colour_px%0d got %0d expected %0d", i, got_grey[i], exp_g[i % 4]);
         end
      end
      checks++;
      if (frame_cnt !== exp_frames) begin
         errors++; $display("FAIL colour_frames got %0d expected %0d", frame_cnt, exp_frames);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_g[NPIX];
      pix[0] = 24'hFFFFFF; exp_g[0] = 8'd249;
      pix[1] = 24'h000000; exp_g[1] = 8'd5;
      pix[2] = 24'hFF0000; exp_g[2] = 8'd78;
      pix[3] = 24'h808080; exp_g[3] = 8'd132;
      pix[4] = 24'h00FF00; exp_g[4] = 8'd151;
      pix[5] = 24'h0000FF; exp_g[5] = 8'd30;
      pix[6] = 24'h808080; exp_g[6] = 8'd132;
      pix[7] = 24'hFF0000; exp_g[7] = 8'd78;
      run_frame(4, 3, 1'b0);
      exp_frames = exp_frames + 16'd1;
      checks++;
      if (n_out !== NPIX) begin
         errors++; $display("FAIL bp_count got %0d expected %0d", n_out, NPIX);
      end
      for (int i = 0; i < NPIX; i++) begin
         checks++;
         if (got_grey[i] !== exp_g[i] || got_flags[i] !== exp_flags(i)) begin
            errors++;
            $display("FAIL bp_px%0d got grey=%0d flags=%b expected grey=%0d flags=%b",
                     i, got_grey[i], got_flags[i], exp_g[i], exp_flags(i));
         end
      end
      checks++;
      if (stall_seen !== 3 || stall_changes !== 0 || s_ready_bad !== 0) begin
         errors++;
         $display("FAIL bp_stall got seen=%0d changes=%0d s_ready_hi=%0d expected 3/0/0",
                  stall_seen, stall_changes, s_ready_bad);
      end
      checks++;
      if (done_cnt !== 1 || frame_cnt !== exp_frames) begin
         errors++;
         $display("FAIL bp_done got done=%0d frames=%0d expected 1/%0d", done_cnt, frame_cnt, exp_frames);
      end
   endtask

   task automatic test_abort();
      int sent;
      int seen_done;
      sent = 0; seen_done = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         s_valid = 1'b1;
         s_rgb   = pix[sent % NPIX];
         m_ready = 1'b1;
         abort   = (sent == 6);
         #1;
         if (abort) break;
         if (s_valid && s_ready) sent++;
         @(negedge clk);
      end
      @(negedge clk); abort = 1'b0; s_valid = 1'b0;
      #1;
      checks++;
      if (sent !== 6 || busy !== 1'b0 || m_valid !== 1'b0 || {m_sof, m_eol, m_eof} !== 3'b000 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_state got sent=%0d busy=%b m_valid=%b flags=%b s_ready=%b expected 6/0/0/000/0",
                  sent, busy, m_valid, {m_sof, m_eol, m_eof}, s_ready);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (done) seen_done++;
      end
      checks++;
      if (seen_done !== 0 || frame_cnt !== exp_frames) begin
         errors++;
         $display("FAIL abort_nodone got done=%0d frames=%0d expected 0/%0d", seen_done, frame_cnt, exp_frames);
      end
      run_frame(1000, 0, 1'b0);
      exp_frames = exp_frames + 16'd1;
      checks++;
      if (got_flags[0] !== 3'b100 || n_out !== NPIX || done_cnt !== 1 || frame_cnt !== exp_frames) begin
         errors++;
         $display("FAIL abort_restart got flags0=%b n=%0d done=%0d frames=%0d expected 100/%0d/1/%0d",
                  got_flags[0], n_out, done_cnt, frame_cnt, NPIX, exp_frames);
      end
   endtask

   task automatic test_ignored_and_reset();
      int bad;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); s_valid = 1'b1; s_rgb = 24'hFFFFFF; #1;
         if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) bad++;
      end
      s_valid = 1'b0;
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL idle_svalid got %0d bad cycles expected 0", bad);
      end
      for (int i = 0; i < NPIX; i++) pix[i] = 24'hFFFFFF;
      run_frame(1000, 0, 1'b1);
      exp_frames = exp_frames + 16'd1;
      checks++;
      if (n_out !== NPIX || extra_out !== 0 || done_cnt !== 1 || frame_cnt !== exp_frames) begin
         errors++;
         $display("FAIL start_spam got n=%0d extra=%0d done=%0d frames=%0d expected %0d/0/1/%0d",
                  n_out, extra_out, done_cnt, frame_cnt, NPIX, exp_frames);
      end
      @(negedge clk); @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL start_spam_idle got busy=%b expected 0", busy);
      end
      // Reset in the middle of a stalled frame.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; s_valid = 1'b1; s_rgb = 24'hFFFFFF; m_ready = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      checks++;
      if (m_valid !== 1'b1 || m_grey !== 8'hF9 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midframe_pre got m_valid=%b grey=%h busy=%b expected 1/f9/1", m_valid, m_grey, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({m_valid, m_grey, m_sof, m_eol, m_eof, busy, done, frame_cnt, s_ready} !== 31'd0) begin
         errors++;
         $display("FAIL async_reset got %h expected 0",
                  {m_valid, m_grey, m_sof, m_eol, m_eof, busy, done, frame_cnt, s_ready});
      end
      s_valid = 1'b0; m_ready = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      exp_frames = 16'd0;
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force dut.frame_cnt_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut.frame_cnt_q;
      @(negedge clk); #1;
      checks++;
      if (frame_cnt !== 16'hFFFF) begin
         errors++; $display("FAIL wrap_preload got %h expected ffff", frame_cnt);
      end
      run_frame(1000, 0, 1'b0);
      checks++;
      if (frame_cnt !== 16'h0000 || done_cnt !== 1) begin
         errors++; $display("FAIL wrap got frames=%h done=%0d expected 0000/1", frame_cnt, done_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_white_frame();
      test_colours();
      test_backpressure();
      test_abort();
      test_ignored_and_reset();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
